// File: rtl/hazard_unit_param_if.sv
// Purpose : bundles the ID/EX/MEM/WB hazard-check inputs and the forwarding,
//           stall and performance outputs of hazard_unit_param.
// Ports   : master = pipeline side (drives register/stage info, reads controls);
//           slave  = hazard unit (reads stage info, drives forwarding/stall/counters).
interface hazard_unit_param_if #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int PERF_W  = 16
);
  logic [NUM_SRC*AW-1:0]   id_rs;
  logic [NUM_SRC-1:0]      id_re;
  logic                    id_is_ctrl;
  logic [AW-1:0]           ex_rd, mem_rd, wb_rd;
  logic                    ex_we, mem_we, wb_we;
  logic [XLEN-1:0]         ex_wdata, mem_wdata, wb_wdata;
  logic                    ex_rdy, mem_rdy, wb_rdy;
  logic                    perf_clr;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic [NUM_SRC-1:0]      fwd_hit;
  logic [NUM_SRC-1:0]      src_stall;
  logic                    data_stall;
  logic                    ctrl_hazard;
  logic                    pc_stall;
  logic                    if_id_stall;
  logic                    id_ex_bubble;
  logic                    pc_update;
  logic [PERF_W-1:0]       data_stall_cnt;
  logic [PERF_W-1:0]       ctrl_stall_cnt;

  modport master (
    output id_rs, id_re, id_is_ctrl,
    output ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we,
    output ex_wdata, mem_wdata, wb_wdata, ex_rdy, mem_rdy, wb_rdy,
    output perf_clr,
    input  fwd_data, fwd_hit, src_stall, data_stall, ctrl_hazard,
    input  pc_stall, if_id_stall, id_ex_bubble, pc_update,
    input  data_stall_cnt, ctrl_stall_cnt
  );

  modport slave (
    input  id_rs, id_re, id_is_ctrl,
    input  ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we,
    input  ex_wdata, mem_wdata, wb_wdata, ex_rdy, mem_rdy, wb_rdy,
    input  perf_clr,
    output fwd_data, fwd_hit, src_stall, data_stall, ctrl_hazard,
    output pc_stall, if_id_stall, id_ex_bubble, pc_update,
    output data_stall_cnt, ctrl_stall_cnt
  );
endinterface

// File: rtl/hazard_unit_param.sv
// Purpose : ID-stage hazard detection + EX/MEM/WB forwarding, control-instruction
//           hold with PC-update strobe, saturating stall counters.
// Latency : forwarding/stall outputs combinational (0 cycles); hold counter and
//           perf counters update on clk.
// Backpressure: a not-ready youngest producer stalls its slot; data_stall freezes
//           PC and IF/ID and bubbles EX, and pauses the control-hold count.
// Ports   : clk, rst (async, active-high) plus the slave side of hazard_unit_param_if.
module hazard_unit_param #(
  parameter int XLEN        = 32,
  parameter int AW          = 5,
  parameter int NUM_SRC     = 2,
  parameter int FWD_EN      = 1,
  parameter int CTRL_CYCLES = 3,
  parameter int PERF_W      = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_unit_param_if.slave bus
);

  localparam logic [3:0] CTRL_N    = 4'(CTRL_CYCLES);
  localparam logic [3:0] CTRL_LAST = 4'(CTRL_CYCLES - 1);

  logic [NUM_SRC*XLEN-1:0] fwd_data_c;
  logic [NUM_SRC-1:0]      fwd_hit_c;
  logic [NUM_SRC-1:0]      src_stall_c;
  logic                    data_stall;
  logic                    ctrl_hazard;
  logic                    started;
  logic [3:0]              ccnt;
  logic [PERF_W-1:0]       data_cnt;
  logic [PERF_W-1:0]       ctrl_cnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    logic [AW-1:0]   rs;
    logic            m_ex, m_mem, m_wb;
    logic            hit_s, stall_s;
    logic [XLEN-1:0] data_s;

    assign rs    = bus.id_rs[g*AW +: AW];
    // x0 is never a real producer, so it is excluded from every match.
    assign m_ex  = bus.id_re[g] & bus.ex_we  & (bus.ex_rd  == rs) & (bus.ex_rd  != '0);
    assign m_mem = bus.id_re[g] & bus.mem_we & (bus.mem_rd == rs) & (bus.mem_rd != '0);
    assign m_wb  = bus.id_re[g] & bus.wb_we  & (bus.wb_rd  == rs) & (bus.wb_rd  != '0);

    always_comb begin
      hit_s   = 1'b0;
      stall_s = 1'b0;
      data_s  = '0;
      if (FWD_EN != 0) begin
        // Only the youngest matching stage counts: if it is not ready, an
        // older ready stage holds a stale value and must not be used.
        if (m_ex) begin
          if (bus.ex_rdy) begin hit_s = 1'b1; data_s = bus.ex_wdata; end
          else            stall_s = 1'b1;
        end else if (m_mem) begin
          if (bus.mem_rdy) begin hit_s = 1'b1; data_s = bus.mem_wdata; end
          else             stall_s = 1'b1;
        end else if (m_wb) begin
          if (bus.wb_rdy) begin hit_s = 1'b1; data_s = bus.wb_wdata; end
          else            stall_s = 1'b1;
        end
      end else begin
        stall_s = m_ex | m_mem | m_wb;
      end
    end

    assign fwd_data_c[g*XLEN +: XLEN] = data_s;
    assign fwd_hit_c[g]               = hit_s;
    assign src_stall_c[g]             = stall_s;
  end

  assign data_stall  = |src_stall_c;
  assign ctrl_hazard = bus.id_is_ctrl & (ccnt < CTRL_N) & ~data_stall & started;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      ccnt     <= 4'd0;
      data_cnt <= '0;
      ctrl_cnt <= '0;
    end else begin
      started <= 1'b1;
      // Hold the count across a data stall so a control instruction that
      // also waits on an operand resumes rather than restarts its hold.
      if (ctrl_hazard)     ccnt <= ccnt + 4'd1;
      else if (!data_stall) ccnt <= 4'd0;

      if (bus.perf_clr)                  data_cnt <= '0;
      else if (data_stall && !(&data_cnt)) data_cnt <= data_cnt + 1'b1;

      if (bus.perf_clr)                   ctrl_cnt <= '0;
      else if (ctrl_hazard && !(&ctrl_cnt)) ctrl_cnt <= ctrl_cnt + 1'b1;
    end
  end

  assign bus.fwd_data       = fwd_data_c;
  assign bus.fwd_hit        = fwd_hit_c;
  assign bus.src_stall      = src_stall_c;
  assign bus.data_stall     = data_stall;
  assign bus.ctrl_hazard    = ctrl_hazard;
  assign bus.pc_stall       = data_stall | ctrl_hazard;
  assign bus.if_id_stall    = data_stall | ctrl_hazard;
  assign bus.id_ex_bubble   = data_stall;
  assign bus.pc_update      = ctrl_hazard & (ccnt == CTRL_LAST);
  assign bus.data_stall_cnt = data_cnt;
  assign bus.ctrl_stall_cnt = ctrl_cnt;

endmodule

// File: tb/tb_hazard_unit_param.sv
module tb_hazard_unit_param;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hit;
    logic [1:0]  stall;
    logic        ds;
    logic        ch;
    logic        pcs;
    logic        ifs;
    logic        bub;
    logic        pcu;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_param_if #(.XLEN(32), .AW(5), .NUM_SRC(2), .PERF_W(16)) m_if ();
  hazard_unit_param_if #(.XLEN(32), .AW(5), .NUM_SRC(2), .PERF_W(16)) nf_if ();
  hazard_unit_param_if #(.XLEN(32), .AW(5), .NUM_SRC(2), .PERF_W(4))  p_if ();

  hazard_unit_param #(.XLEN(32), .AW(5), .NUM_SRC(2), .FWD_EN(1), .CTRL_CYCLES(3), .PERF_W(16))
    u_main (.clk(clk), .rst(rst), .bus(m_if.slave));
  hazard_unit_param #(.XLEN(32), .AW(5), .NUM_SRC(2), .FWD_EN(0), .CTRL_CYCLES(3), .PERF_W(16))
    u_nofwd (.clk(clk), .rst(rst), .bus(nf_if.slave));
  hazard_unit_param #(.XLEN(32), .AW(5), .NUM_SRC(2), .FWD_EN(1), .CTRL_CYCLES(3), .PERF_W(4))
    u_p4 (.clk(clk), .rst(rst), .bus(p_if.slave));

  obs_t obs_m, obs_nf;
  assign obs_m  = {m_if.fwd_data, m_if.fwd_hit, m_if.src_stall, m_if.data_stall, m_if.ctrl_hazard,
                   m_if.pc_stall, m_if.if_id_stall, m_if.id_ex_bubble, m_if.pc_update};
  assign obs_nf = {nf_if.fwd_data, nf_if.fwd_hit, nf_if.src_stall, nf_if.data_stall, nf_if.ctrl_hazard,
                   nf_if.pc_stall, nf_if.if_id_stall, nf_if.id_ex_bubble, nf_if.pc_update};

  obs_t exp_q[$];
  obs_t cur_m = '0;
  obs_t cur_p = '0;
  int total = 0;
  int bad   = 0;

  // Counter reference model, driven by the bench's own per-cycle expectations.
  logic [15:0] ds_m, cs_m;
  logic [3:0]  ds_p;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_m <= '0; cs_m <= '0; ds_p <= '0;
    end else begin
      if (m_if.perf_clr) begin
        ds_m <= '0; cs_m <= '0;
      end else begin
        if (cur_m.ds && ds_m != 16'hFFFF) ds_m <= ds_m + 16'd1;
        if (cur_m.ch && cs_m != 16'hFFFF) cs_m <= cs_m + 16'd1;
      end
      if (cur_p.ds && ds_p != 4'hF) ds_p <= ds_p + 4'd1;
    end
  end

  function automatic obs_t mk(input logic [63:0] d, input logic [1:0] h, input logic [1:0] s,
                              input logic ds, input logic ch, input logic pcu);
    obs_t o;
    o.data = d; o.hit = h; o.stall = s; o.ds = ds; o.ch = ch;
    o.pcs = ds | ch; o.ifs = ds | ch; o.bub = ds; o.pcu = pcu;
    return o;
  endfunction

  task automatic idle_m();
    m_if.id_rs = '0; m_if.id_re = '0; m_if.id_is_ctrl = 1'b0;
    m_if.ex_rd = '0; m_if.mem_rd = '0; m_if.wb_rd = '0;
    m_if.ex_we = 1'b0; m_if.mem_we = 1'b0; m_if.wb_we = 1'b0;
    m_if.ex_wdata = '0; m_if.mem_wdata = '0; m_if.wb_wdata = '0;
    m_if.ex_rdy = 1'b0; m_if.mem_rdy = 1'b0; m_if.wb_rdy = 1'b0;
    m_if.perf_clr = 1'b0;
  endtask

  task automatic idle_nf();
    nf_if.id_rs = '0; nf_if.id_re = '0; nf_if.id_is_ctrl = 1'b0;
    nf_if.ex_rd = '0; nf_if.mem_rd = '0; nf_if.wb_rd = '0;
    nf_if.ex_we = 1'b0; nf_if.mem_we = 1'b0; nf_if.wb_we = 1'b0;
    nf_if.ex_wdata = '0; nf_if.mem_wdata = '0; nf_if.wb_wdata = '0;
    nf_if.ex_rdy = 1'b0; nf_if.mem_rdy = 1'b0; nf_if.wb_rdy = 1'b0;
    nf_if.perf_clr = 1'b0;
  endtask

  task automatic idle_p();
    p_if.id_rs = '0; p_if.id_re = '0; p_if.id_is_ctrl = 1'b0;
    p_if.ex_rd = '0; p_if.mem_rd = '0; p_if.wb_rd = '0;
    p_if.ex_we = 1'b0; p_if.mem_we = 1'b0; p_if.wb_we = 1'b0;
    p_if.ex_wdata = '0; p_if.mem_wdata = '0; p_if.wb_wdata = '0;
    p_if.ex_rdy = 1'b0; p_if.mem_rdy = 1'b0; p_if.wb_rdy = 1'b0;
    p_if.perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    idle_m();
    m_if.id_is_ctrl = 1'b1;
    e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_m !== e) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs_m, e); end
    total++;
    if (m_if.data_stall_cnt !== 16'd0 || m_if.ctrl_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%h/%h want=0/0", m_if.data_stall_cnt, m_if.ctrl_stall_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e); cur_m = e;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_m !== e) begin bad++; $display("FAIL not_started_ctrl got=%h want=%h", obs_m, e); end
    m_if.id_is_ctrl = 1'b0;
    @(posedge clk); #1;
    cur_m = '0;
  endtask

  task automatic test_fwd_ex();
    obs_t e;
    idle_m();
    m_if.ex_rd = 5'd5; m_if.ex_we = 1'b1; m_if.ex_wdata = 32'h0000_1234; m_if.ex_rdy = 1'b1;
    m_if.id_rs = {5'd0, 5'd5}; m_if.id_re = 2'b01;
    e = mk({32'h0, 32'h0000_1234}, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e); cur_m = e;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_m !== e) begin bad++; $display("FAIL fwd_ex got=%h want=%h", obs_m, e); end
    @(posedge clk); #1;
    idle_m(); cur_m = '0;
  endtask

  task automatic test_priority();
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      idle_m();
      m_if.mem_rd = 5'd7; m_if.mem_we = 1'b1; m_if.mem_wdata = 32'hAAAA_0001; m_if.mem_rdy = 1'b1;
      m_if.wb_rd  = 5'd7; m_if.wb_we  = 1'b1; m_if.wb_wdata  = 32'hBBBB_0002; m_if.wb_rdy  = 1'b1;
      m_if.ex_we = 1'b1; m_if.ex_wdata = 32'hCCCC_0003; m_if.id_re = 2'b11;
      if (k == 0) begin
        m_if.ex_rd = 5'd3; m_if.ex_rdy = 1'b1; m_if.id_rs = {5'd3, 5'd7};
        e = mk({32'hCCCC_0003, 32'hAAAA_0001}, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      end else begin
        m_if.ex_rd = 5'd7; m_if.ex_rdy = 1'b0; m_if.id_rs = {5'd7, 5'd7};
        e = mk(64'h0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
      end
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL priority[%0d] got=%h want=%h", k, obs_m, e); end
      @(posedge clk); #1;
    end
    idle_m(); cur_m = '0;
  endtask

  task automatic test_load_use();
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      idle_m();
      m_if.id_rs = {5'd6, 5'd0}; m_if.id_re = 2'b10;
      m_if.mem_rd = 5'd6; m_if.mem_we = 1'b1; m_if.mem_rdy = 1'b1;
      if (k == 0) begin
        m_if.ex_rd = 5'd6; m_if.ex_we = 1'b1; m_if.ex_rdy = 1'b0; m_if.mem_wdata = 32'h0000_0011;
        e = mk(64'h0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
      end else begin
        m_if.mem_wdata = 32'hDEAD_BEEF;
        e = mk({32'hDEAD_BEEF, 32'h0}, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
      end
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL load_use[%0d] got=%h want=%h", k, obs_m, e); end
      if (k == 1) begin
        total++;
        if (m_if.data_stall_cnt !== ds_m) begin
          bad++; $display("FAIL data_stall_cnt got=%0d want=%0d", m_if.data_stall_cnt, ds_m);
        end
      end
      @(posedge clk); #1;
    end
    idle_m(); cur_m = '0;
  endtask

  task automatic test_x0_and_re();
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      idle_m();
      m_if.ex_we = 1'b1; m_if.ex_rdy = 1'b1; m_if.ex_wdata = 32'h0000_0BAD;
      if (k == 0) begin
        m_if.ex_rd = 5'd0; m_if.id_rs = {5'd0, 5'd0}; m_if.id_re = 2'b01;
      end else begin
        m_if.ex_rd = 5'd5; m_if.id_rs = {5'd0, 5'd5}; m_if.id_re = 2'b00;
      end
      e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL x0_re[%0d] got=%h want=%h", k, obs_m, e); end
      @(posedge clk); #1;
    end
    idle_m(); cur_m = '0;
  endtask

  // Control held for n cycles; hold pattern repeats every CTRL_CYCLES+1 cycles.
  task automatic test_ctrl(input int n, input string nm);
    obs_t e;
    for (int k = 0; k <= n; k++) begin
      idle_m();
      m_if.id_is_ctrl = (k < n);
      if (k < n) e = mk(64'h0, 2'b00, 2'b00, 1'b0, (k % 4) != 3, (k % 4) == 2);
      else       e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", nm, k, obs_m, e); end
      @(posedge clk); #1;
    end
    idle_m(); cur_m = '0;
    @(negedge clk);
    total++;
    if (m_if.ctrl_stall_cnt !== cs_m) begin
      bad++; $display("FAIL %s_ctrl_cnt got=%0d want=%0d", nm, m_if.ctrl_stall_cnt, cs_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jalr_load_use();
    obs_t e;
    logic [5:0] st, ch, pu;
    st = 6'b000101;  // cycle k uses bit k
    ch = 6'b011010;
    pu = 6'b010000;
    for (int k = 0; k < 7; k++) begin
      idle_m();
      m_if.id_is_ctrl = (k < 6);
      if (k < 6 && st[k]) begin
        m_if.ex_rd = 5'd6; m_if.ex_we = 1'b1; m_if.ex_rdy = 1'b0;
        m_if.id_rs = {5'd0, 5'd6}; m_if.id_re = 2'b01;
        e = mk(64'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
      end else if (k < 6) begin
        e = mk(64'h0, 2'b00, 2'b00, 1'b0, ch[k], pu[k]);
      end else begin
        e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      end
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL jalr_load_use[%0d] got=%h want=%h", k, obs_m, e); end
      @(posedge clk); #1;
    end
    idle_m(); cur_m = '0;
  endtask

  task automatic test_perf_clr();
    obs_t e;
    idle_m();
    m_if.ex_rd = 5'd6; m_if.ex_we = 1'b1; m_if.ex_rdy = 1'b0;
    m_if.id_rs = {5'd0, 5'd6}; m_if.id_re = 2'b01; m_if.perf_clr = 1'b1;
    e = mk(64'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(e); cur_m = e;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_m !== e) begin bad++; $display("FAIL perf_clr_cycle got=%h want=%h", obs_m, e); end
    @(posedge clk); #1;
    idle_m(); cur_m = '0;
    @(negedge clk);
    total++;
    if (m_if.data_stall_cnt !== ds_m || m_if.ctrl_stall_cnt !== cs_m) begin
      bad++; $display("FAIL perf_clr got=%0d/%0d want=%0d/%0d", m_if.data_stall_cnt, m_if.ctrl_stall_cnt, ds_m, cs_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nofwd();
    obs_t e;
    for (int k = 0; k < 3; k++) begin
      idle_nf();
      if (k == 0) begin
        nf_if.wb_rd = 5'd9; nf_if.wb_we = 1'b1; nf_if.wb_rdy = 1'b1; nf_if.wb_wdata = 32'h0000_0077;
        nf_if.id_rs = {5'd0, 5'd9}; nf_if.id_re = 2'b01;
        e = mk(64'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
      end else if (k == 1) begin
        nf_if.ex_rd = 5'd4; nf_if.ex_we = 1'b1; nf_if.ex_rdy = 1'b1; nf_if.ex_wdata = 32'h0000_0005;
        nf_if.id_rs = {5'd4, 5'd0}; nf_if.id_re = 2'b10;
        e = mk(64'h0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
      end else begin
        nf_if.wb_rd = 5'd9; nf_if.wb_we = 1'b0; nf_if.wb_rdy = 1'b1;
        nf_if.id_rs = {5'd0, 5'd9}; nf_if.id_re = 2'b01;
        e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      end
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_nf !== e) begin bad++; $display("FAIL nofwd[%0d] got=%h want=%h", k, obs_nf, e); end
      @(posedge clk); #1;
    end
    idle_nf();
  endtask

  task automatic test_perf_sat();
    for (int k = 0; k < 20; k++) begin
      idle_p();
      p_if.ex_rd = 5'd6; p_if.ex_we = 1'b1; p_if.ex_rdy = 1'b0;
      p_if.id_rs = {5'd0, 5'd6}; p_if.id_re = 2'b01;
      cur_p = mk(64'h0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (k == 9) begin
        total++;
        if (p_if.data_stall_cnt !== ds_p) begin
          bad++; $display("FAIL perf_mid got=%0d want=%0d", p_if.data_stall_cnt, ds_p);
        end
      end
    end
    idle_p(); cur_p = '0;
    @(negedge clk);
    total++;
    if (p_if.data_stall_cnt !== ds_p || ds_p !== 4'hF) begin
      bad++; $display("FAIL perf_sat got=%0d want=%0d", p_if.data_stall_cnt, ds_p);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_hold();
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      idle_m(); m_if.id_is_ctrl = 1'b1;
      e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL rst_pre[%0d] got=%h want=%h", k, obs_m, e); end
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e); cur_m = e;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_m !== e || m_if.ctrl_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_during got=%h cnt=%0d want=%h cnt=0", obs_m, m_if.ctrl_stall_cnt, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // first cycle after release: not started; then a fresh full hold
    for (int k = 0; k < 5; k++) begin
      if (k == 0) e = mk(64'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      else        e = mk(64'h0, 2'b00, 2'b00, 1'b0, k != 4, k == 3);
      exp_q.push_back(e); cur_m = e;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (obs_m !== e) begin bad++; $display("FAIL rst_after[%0d] got=%h want=%h", k, obs_m, e); end
      @(posedge clk); #1;
    end
    idle_m(); cur_m = '0;
    @(negedge clk);
    total++;
    if (m_if.ctrl_stall_cnt !== cs_m) begin
      bad++; $display("FAIL rst_ctrl_cnt got=%0d want=%0d", m_if.ctrl_stall_cnt, cs_m);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_m(); idle_nf(); idle_p();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fwd_ex();
    test_priority();
    test_load_use();
    test_x0_and_re();
    test_ctrl(4, "ctrl_hold");
    test_ctrl(8, "back_to_back");
    test_jalr_load_use();
    test_perf_clr();
    test_nofwd();
    test_perf_sat();
    test_rst_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised hazard detection and forwarding unit for the 5-stage pipeline CPU. It generalises the fixed two-source, fixed-penalty design.
- Sits beside the ID stage. It compares ID source registers against EX/MEM/WB destinations, and supplies forwarded operands, per-stage stall/bubble controls, a branch-resolution PC-update strobe and saturating stall counters.
- Forwarding can be disabled by parameter, giving a stall-only interlock mode.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width.
- NUM_SRC, 2, number of ID source operands checked (1..4).
- FWD_EN, 1, 1 = forward from EX/MEM/WB; 0 = stall on any pending match, no forwarding.
- CTRL_CYCLES, 3, cycles IF/ID is held for a control instruction in ID (1..15).
- PERF_W, 16, width of the stall performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  NUM_SRC*AW  ID source register addresses; slot i = bits [i*AW +: AW]
- id_re  in  NUM_SRC  ID source read enables
- id_is_ctrl  in  1  ID holds a branch, jal or jalr
- ex_rd, mem_rd, wb_rd  in  AW each  destination registers
- ex_we, mem_we, wb_we  in  1 each  register-file write enables
- ex_wdata, mem_wdata, wb_wdata  in  XLEN each  value the stage will write back (already wsel-muxed)
- ex_rdy, mem_rdy, wb_rdy  in  1 each  wdata is valid now (ex_rdy=0 for a load in EX)
- perf_clr  in  1  synchronous clear of the counters
- fwd_data  out  NUM_SRC*XLEN  forwarded operand for each slot
- fwd_hit  out  NUM_SRC  slot i takes fwd_data instead of the register file
- src_stall  out  NUM_SRC  slot i cannot be satisfied this cycle
- data_stall  out  1  OR of src_stall
- ctrl_hazard  out  1  control hold active
- pc_stall  out  1  = data_stall | ctrl_hazard
- if_id_stall  out  1  = data_stall | ctrl_hazard
- id_ex_bubble  out  1  = data_stall; inject a NOP into EX
- pc_update  out  1  one-cycle strobe: branch target may be loaded
- data_stall_cnt  out  PERF_W  cycles with data_stall=1
- ctrl_stall_cnt  out  PERF_W  cycles with ctrl_hazard=1

Behaviour:
- Match rule: match(s,i) = (s_rd == rs_i) & s_we & id_re[i] & (s_rd != 0). Writes to x0 are never matched.
- FWD_EN=1, per slot:
  - The youngest matching stage is selected, in priority EX > MEM > WB.
  - If the selected stage's rdy=1: fwd_hit[i]=1 and fwd_data slot = that stage's wdata.
  - If the selected stage's rdy=0: src_stall[i]=1, fwd_hit[i]=0, and the slot's fwd_data=0. An older ready stage is never used past a not-ready younger one.
- FWD_EN=0: src_stall[i] = any match in EX, MEM or WB. fwd_hit and fwd_data are all 0.
- No match in a slot: fwd_hit=0, fwd_data=0, src_stall=0.
- Forwarding and stall outputs are combinational and have zero latency.
- started flag: 0 in reset, set to 1 on the first clk edge after reset deasserts. While started=0, ctrl_hazard is forced to 0.
- Control counter ccnt, 4 bits:
  - ctrl_hazard = id_is_ctrl & (ccnt < CTRL_CYCLES) & ~data_stall & started.
  - On each clk edge: if ctrl_hazard then ccnt+1; else if data_stall then hold; else 0.
  - Holding ccnt on data_stall lets a control instruction that also has a data hazard resume its count afterwards.
  - pc_update = ctrl_hazard & (ccnt == CTRL_CYCLES-1).
  - Once ccnt reaches CTRL_CYCLES, ctrl_hazard drops, so the instruction leaves ID. The next cycle ccnt returns to 0.
  - Back-to-back control instructions therefore each see the full CTRL_CYCLES hold.
- Counters:
  - Increment when their condition is 1, saturating at all-ones.
  - perf_clr takes priority and loads 0.
- Reset values: ccnt=0, started=0, both counters 0. All combinational outputs follow from the inputs: the forwarding and data-stall outputs depend only on pipeline inputs, and ctrl_hazard=0 and pc_update=0 while started=0.
- Reset asserted mid-hold clears ccnt immediately. No pc_update is issued until the hold restarts.

Test Plan:
- EX ALU writes x5=0x00001234 (rdy=1), ID rs1=x5, re=1 -> fwd_hit[0]=1, fwd_data[0]=0x00001234, data_stall=0.
- EX load to x6 (ex_rdy=0), MEM also writes x6=0x11, ID rs2=x6 -> src_stall[1]=1, id_ex_bubble=1, fwd_hit[1]=0. Next cycle the load is in MEM with mem_wdata=0xDEADBEEF, rdy=1 -> fwd_data[1]=0xDEADBEEF, stall 0.
- ex_rd=0, we=1, ID rs1=x0 -> no hit, no stall. Same stimulus with id_re=0 on rs=x5 -> no hit.
- CTRL_CYCLES=3, id_is_ctrl held high -> ctrl_hazard high for 3 cycles, pc_update only on the 3rd, then low. ctrl_stall_cnt=3.
- jalr in ID with a load-use hazard for 1 cycle -> ctrl_hazard=0 while data_stall=1 and ccnt holds. Then 3 ctrl cycles follow, with pc_update on the last.
- The following three checks:
  - FWD_EN=0, WB-only match -> stall, fwd_hit=0.
  - PERF_W=4, 20 stall cycles -> data_stall_cnt=15.
  - rst pulse mid-hold -> ccnt=0 and ctrl_hazard=0 for the first cycle after release.
